// File: rtl/mem_stage.sv
// MEM pipeline stage: 64-word data memory plus the MEM and WB forwarding registers.
// Loads read the memory word before any store on the same edge; memory contents survive reset.
module mem_stage (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        EXRegWrite,
    input  logic        EXMemRead,
    input  logic        EXMemWrite,
    input  logic [4:0]  EXRd,
    input  logic [31:0] EXData,
    input  logic [31:0] EXALUData,
    input  logic        Stall,
    output logic        MEMRegWrite,
    output logic [31:0] MEMData,
    output logic [4:0]  MEMRd,
    output logic        WBRegWrite,
    output logic [31:0] WBData,
    output logic [4:0]  WBRd
);

    logic [31:0] r_mem [0:63];

    logic        r_memRegWrite;
    logic [31:0] r_memData;
    logic [4:0]  r_memRd;
    logic        r_wbRegWrite;
    logic [31:0] r_wbData;
    logic [4:0]  r_wbRd;

    logic [5:0]  w_wordIdx;
    logic        w_isLoad;
    logic [31:0] w_memResult;
    logic        w_unusedAddrBits;

    // Only bits [7:2] select a word, so byte addresses wrap every 256 bytes.
    assign w_wordIdx        = EXALUData[7:2];
    assign w_unusedAddrBits = ^{EXALUData[31:8], EXALUData[1:0]};

    // A combined read+write is treated as a store, so the ALU value is forwarded instead.
    assign w_isLoad    = EXMemRead & ~EXMemWrite;
    assign w_memResult = w_isLoad ? r_mem[w_wordIdx] : EXALUData;

    // Memory shares the reset domain so that a clock during reset cannot write it, but is never cleared.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_memRegWrite <= 1'b0;
            r_memData     <= 32'h0;
            r_memRd       <= 5'd0;
            r_wbRegWrite  <= 1'b0;
            r_wbData      <= 32'h0;
            r_wbRd        <= 5'd0;
        end else if (!Stall) begin
            r_memRegWrite <= EXRegWrite & (EXRd != 5'd0);
            r_memData     <= w_memResult;
            r_memRd       <= EXRd;
            r_wbRegWrite  <= r_memRegWrite;
            r_wbData      <= r_memData;
            r_wbRd        <= r_memRd;
            if (EXMemWrite) begin
                r_mem[w_wordIdx] <= EXData;
            end
        end
    end

    assign MEMRegWrite = r_memRegWrite;
    assign MEMData     = r_memData;
    assign MEMRd       = r_memRd;
    assign WBRegWrite  = r_wbRegWrite;
    assign WBData      = r_wbData;
    assign WBRd        = r_wbRd;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_mem_stage;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        EXRegWrite = 1'b0;
    logic        EXMemRead = 1'b0;
    logic        EXMemWrite = 1'b0;
    logic [4:0]  EXRd = 5'd0;
    logic [31:0] EXData = 32'h0;
    logic [31:0] EXALUData = 32'h0;
    logic        Stall = 1'b0;
    logic        MEMRegWrite;
    logic [31:0] MEMData;
    logic [4:0]  MEMRd;
    logic        WBRegWrite;
    logic [31:0] WBData;
    logic [4:0]  WBRd;

    int checks = 0;
    int passes = 0;

    mem_stage dut (
        .Clk(Clk), .nReset(nReset),
        .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead), .EXMemWrite(EXMemWrite),
        .EXRd(EXRd), .EXData(EXData), .EXALUData(EXALUData), .Stall(Stall),
        .MEMRegWrite(MEMRegWrite), .MEMData(MEMData), .MEMRd(MEMRd),
        .WBRegWrite(WBRegWrite), .WBData(WBData), .WBRd(WBRd)
    );

    always #5 Clk = ~Clk;

    // Reference model: a word array for memory and a history of accepted results (newest first).
    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    logic [31:0] refMem [64];
    entry_t      hist[$];

    always @(posedge Clk or negedge nReset) begin
        entry_t e;
        if (!nReset) begin
            hist.delete();
        end else if (!Stall) begin
            e.rw   = EXRegWrite && (EXRd != 5'd0);
            e.rd   = EXRd;
            e.data = (EXMemRead && !EXMemWrite) ? refMem[int'(EXALUData % 256) / 4] : EXALUData;
            if (EXMemWrite) refMem[int'(EXALUData % 256) / 4] = EXData;
            hist.push_front(e);
            if (hist.size() > 2) void'(hist.pop_back());
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    endtask

    // Every cycle, compare all six outputs against the model's view of the last two accepted results.
    always @(negedge Clk) begin
        entry_t m;
        entry_t w;
        m = '{rw: 1'b0, rd: 5'd0, data: 32'h0};
        w = '{rw: 1'b0, rd: 5'd0, data: 32'h0};
        if (hist.size() > 0) m = hist[0];
        if (hist.size() > 1) w = hist[1];
        checkOutput("model MEMRegWrite", {31'h0, MEMRegWrite}, {31'h0, m.rw});
        checkOutput("model MEMRd", {27'h0, MEMRd}, {27'h0, m.rd});
        checkOutput("model MEMData", MEMData, m.data);
        checkOutput("model WBRegWrite", {31'h0, WBRegWrite}, {31'h0, w.rw});
        checkOutput("model WBRd", {27'h0, WBRd}, {27'h0, w.rd});
        checkOutput("model WBData", WBData, w.data);
    end

    // Drive one EX-stage instruction, then return just after the edge that accepts it.
    task automatic applyStimulus(input logic rw, input logic mr, input logic mw, input logic [4:0] rd,
                                 input logic [31:0] data, input logic [31:0] alu, input logic stall);
        EXRegWrite = rw;
        EXMemRead  = mr;
        EXMemWrite = mw;
        EXRd       = rd;
        EXData     = data;
        EXALUData  = alu;
        Stall      = stall;
        @(posedge Clk);
        #1;
    endtask

    task automatic applyNop();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("reset MEMData", MEMData, 32'h0);
        checkOutput("reset WBRegWrite", {31'h0, WBRegWrite}, 32'h0);
        nReset = 1'b1;

        // Give every memory word a defined value so later random loads have known contents.
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, $urandom, 32'(i * 4), 1'b0);
        end

        // ALU pass-through
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd3, 32'h0, 32'h1234_5678, 1'b0);
        checkOutput("pass MEMRegWrite", {31'h0, MEMRegWrite}, 32'h1);
        checkOutput("pass MEMRd", {27'h0, MEMRd}, 32'd3);
        checkOutput("pass MEMData", MEMData, 32'h1234_5678);
        applyNop();
        checkOutput("pass WBData", WBData, 32'h1234_5678);
        checkOutput("pass WBRd", {27'h0, WBRd}, 32'd3);
        checkOutput("pass WBRegWrite", {31'h0, WBRegWrite}, 32'h1);

        // Store then load at an aliased address
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'hdead_beef, 32'h0000_0010, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 32'h0000_0110, 1'b0);
        checkOutput("wrap load MEMData", MEMData, 32'hdead_beef);
        checkOutput("wrap load MEMRd", {27'h0, MEMRd}, 32'd4);

        // Rd=0 never writes back
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'hffff_ffff, 1'b0);
        checkOutput("rd0 MEMRegWrite", {31'h0, MEMRegWrite}, 32'h0);
        checkOutput("rd0 MEMData", MEMData, 32'hffff_ffff);
        applyNop();
        checkOutput("rd0 WBRegWrite", {31'h0, WBRegWrite}, 32'h0);

        // Stall holds everything and suppresses the store
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'h1111_0000, 32'h20, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'hcafe_0000, 32'h20, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'hcafe_0000, 32'h20, 1'b1);
        checkOutput("stall MEMData held", MEMData, 32'h20);
        checkOutput("stall WBData held", WBData, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h20, 1'b0);
        checkOutput("stall load prior", MEMData, 32'h1111_0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'hcafe_0000, 32'h20, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h20, 1'b0);
        checkOutput("stall store done", MEMData, 32'hcafe_0000);

        // Asynchronous reset between edges; a clock during reset must not write memory
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd5, 32'h0, 32'h1234_0000, 1'b0);
        checkOutput("pre-reset MEMData", MEMData, 32'h1234_0000);
        #1;
        nReset = 1'b0;
        #1;
        checkOutput("async MEMData", MEMData, 32'h0);
        checkOutput("async MEMRegWrite", {31'h0, MEMRegWrite}, 32'h0);
        checkOutput("async MEMRd", {27'h0, MEMRd}, 32'h0);
        checkOutput("async WBData", WBData, 32'h0);
        checkOutput("async WBRd", {27'h0, WBRd}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd6, 32'h9999_9999, 32'h10, 1'b0);
        checkOutput("in-reset MEMData", MEMData, 32'h0);
        nReset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd6, 32'h0, 32'h10, 1'b0);
        checkOutput("post-reset load", MEMData, 32'hdead_beef);

        // Read and write together: store wins, ALU value forwarded
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_5432, 32'h08, 1'b0);
        checkOutput("conflict MEMData", MEMData, 32'h0000_0008);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 32'h0, 32'h08, 1'b0);
        checkOutput("conflict load", MEMData, 32'h0000_5432);

        // Random traffic concentrated on a few words to exercise store/load hazards
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            logic [2:0]  w;
            r = $urandom;
            w = 3'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), $urandom, {r[31:8], 3'b000, w, r[1:0]},
                          ($urandom_range(0, 4) == 0));
        end

        applyNop();
        @(negedge Clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
